// File: rtl/trig_playback.sv
// trig_playback: plays a stored waveform from the sample BRAM to the DAC path on
// each rising edge of cpu_flag, len samples per repetition for reps repetitions.
module trig_playback #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_flag,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [15:0]       num_reps,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic              done,
  output logic              trig_missed
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned REP_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic                flag_q;
  logic [LEN_W-1:0]    len, len_d;
  logic [REP_W-1:0]    reps, reps_d;
  logic [REP_W-1:0]    rep_cnt, rep_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_en_d;
  logic                busy_d;
  logic                done_d;
  logic                trig_missed_d;
  logic [LATENCY-1:0]  en_pipe;

  logic                trig_c;
  logic                last_addr_c;
  logic                last_rep_c;
  logic                drain_busy_c;

  // Control registers: FSM state, latched burst parameters, BRAM port and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      flag_q      <= 1'b1;
      len         <= '0;
      reps        <= '0;
      rep_cnt     <= '0;
      mem_addr    <= '0;
      mem_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      state       <= state_d;
      flag_q      <= cpu_flag;
      len         <= len_d;
      reps        <= reps_d;
      rep_cnt     <= rep_cnt_d;
      mem_addr    <= mem_addr_d;
      mem_en      <= mem_en_d;
      busy        <= busy_d;
      done        <= done_d;
      trig_missed <= trig_missed_d;
    end
  end

  // Next-state and next-output logic for the playback sequencer
  always_comb begin
    state_d       = state;
    len_d         = len;
    reps_d        = reps;
    rep_cnt_d     = rep_cnt;
    mem_addr_d    = mem_addr;
    mem_en_d      = 1'b0;
    busy_d        = busy;
    done_d        = 1'b0;

    trig_c        = cpu_flag & ~flag_q;
    trig_missed_d = trig_c && (state != IDLE);
    last_addr_c   = ({1'b0, mem_addr} == (len - LEN_W'(1)));
    last_rep_c    = (rep_cnt == (reps - REP_W'(1)));

    // Reads still in flight that have not yet reached the output stage
    drain_busy_c = mem_en;
    for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
      drain_busy_c = drain_busy_c | en_pipe[i];
    end

    case (state)
      IDLE: begin
        if (trig_c) begin
          len_d      = num_samples;
          reps_d     = (num_reps == '0) ? REP_W'(1) : num_reps;
          rep_cnt_d  = '0;
          mem_addr_d = '0;
          busy_d     = 1'b1;
          if (num_samples == '0) begin
            state_d = DONE;
          end else begin
            state_d  = PLAY;
            mem_en_d = 1'b1;
          end
        end
      end
      PLAY: begin
        if (last_addr_c) begin
          mem_addr_d = '0;
          if (last_rep_c) begin
            state_d = DRAIN;
          end else begin
            rep_cnt_d = rep_cnt + REP_W'(1);
            mem_en_d  = 1'b1;
          end
        end else begin
          mem_addr_d = mem_addr + ADDR_W'(1);
          mem_en_d   = 1'b1;
        end
      end
      DRAIN: begin
        // Leave when only the final sample remains, so DONE lines up with the last valid
        if (!drain_busy_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Read-latency tracking and registered DAC output; data holds between valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe   <= '0;
      dac_valid <= 1'b0;
      dac_data  <= '0;
    end else begin
      en_pipe[0] <= mem_en;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        en_pipe[i] <= en_pipe[i-1];
      end
      dac_valid <= en_pipe[LATENCY-1];
      if (en_pipe[LATENCY-1]) begin
        dac_data <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_trig_playback.sv
// Directed bench for trig_playback: a full-size instance and an ADDR_W=4 instance,
// each fed by a BRAM model returning addr+0x100 with a 2-cycle read latency.
module tb_trig_playback;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag;
  logic        sel;
  logic [14:0] ns_in;
  logic [15:0] nr_in;

  logic        b_flag, s_flag;
  logic [13:0] b_addr;
  logic [3:0]  s_addr;
  logic        b_en, s_en;
  logic [15:0] b_mdata, s_mdata;
  logic [15:0] b_data, s_data;
  logic        b_valid, s_valid, b_busy, s_busy, b_done, s_done, b_miss, s_miss;

  logic [15:0] b_p0 = '0, b_p1 = '0, s_p0 = '0, s_p1 = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign b_flag = flag & ~sel;
  assign s_flag = flag & sel;

  trig_playback #(.ADDR_W(14), .DATA_W(16), .LATENCY(LAT)) u_big (
    .clk(clk), .rst(rst), .cpu_flag(b_flag), .num_samples(ns_in), .num_reps(nr_in),
    .mem_addr(b_addr), .mem_en(b_en), .mem_data(b_mdata), .dac_data(b_data),
    .dac_valid(b_valid), .busy(b_busy), .done(b_done), .trig_missed(b_miss)
  );

  trig_playback #(.ADDR_W(4), .DATA_W(16), .LATENCY(LAT)) u_small (
    .clk(clk), .rst(rst), .cpu_flag(s_flag), .num_samples(ns_in[4:0]), .num_reps(nr_in),
    .mem_addr(s_addr), .mem_en(s_en), .mem_data(s_mdata), .dac_data(s_data),
    .dac_valid(s_valid), .busy(s_busy), .done(s_done), .trig_missed(s_miss)
  );

  // BRAM models: data for the address presented in cycle c appears in cycle c+2
  always @(posedge clk) begin
    b_p0 <= 16'h100 + 16'(b_addr);
    b_p1 <= b_p0;
    s_p0 <= 16'h100 + 16'(s_addr);
    s_p1 <= s_p0;
  end
  assign b_mdata = b_p1;
  assign s_mdata = s_p1;

  logic [13:0] o_addr;
  logic [15:0] o_data;
  logic        o_en, o_valid, o_busy, o_done, o_miss;
  assign o_addr  = sel ? 14'(s_addr) : b_addr;
  assign o_data  = sel ? s_data  : b_data;
  assign o_en    = sel ? s_en    : b_en;
  assign o_valid = sel ? s_valid : b_valid;
  assign o_busy  = sel ? s_busy  : b_busy;
  assign o_done  = sel ? s_done  : b_done;
  assign o_miss  = sel ? s_miss  : b_miss;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One triggered burst; called at a negedge with flag low for at least a cycle.
  // Returns at the negedge of the cycle after the expected done pulse.
  task automatic run_burst(input string tag, input int ns, input int nr,
                           input int exp_len, input int exp_reps,
                           input bit hold, input bit change_in, input int exp_missed);
    int exp_done, exp_n;
    int first_v, nv, ne, data_err, addr_err, gaps, busy_cnt, done_cnt, done_at, miss_cnt;
    bit prev_v;
    ns_in = 15'(ns);
    nr_in = 16'(nr);
    flag  = 1'b1;
    exp_n    = exp_len * exp_reps;
    exp_done = (exp_len == 0) ? 2 : LAT + 2 + exp_n;
    first_v = -1; nv = 0; ne = 0; data_err = 0; addr_err = 0; gaps = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; miss_cnt = 0; prev_v = 1'b0;
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, ":busy_c1"}, int'(o_busy), 1);
        chk({tag, ":en_c1"}, int'(o_en), int'(exp_len != 0));
        chk({tag, ":addr_c1"}, int'(o_addr), 0);
      end
      if (o_busy) busy_cnt++;
      if (o_en) begin
        if (exp_len == 0 || int'(o_addr) != ne % exp_len) addr_err++;
        ne++;
      end
      if (o_valid) begin
        if (first_v < 0) first_v = k;
        else if (!prev_v) gaps++;
        if (exp_len == 0 || int'(o_data) != 32'h100 + (nv % exp_len)) data_err++;
        nv++;
      end
      prev_v = o_valid;
      if (o_miss) miss_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (!hold) flag = 1'b0;
      if (hold && k == 3) flag = 1'b0;
      if (hold && k == 4) flag = 1'b1;
      if (change_in && k == 2) begin
        ns_in = 15'd7;
        nr_in = 16'd5;
      end
    end
    chk({tag, ":first_valid"}, first_v, (exp_len == 0) ? -1 : LAT + 2);
    chk({tag, ":n_valid"}, nv, exp_n);
    chk({tag, ":n_mem_en"}, ne, exp_n);
    chk({tag, ":gaps"}, gaps, 0);
    chk({tag, ":data_err"}, data_err, 0);
    chk({tag, ":addr_err"}, addr_err, 0);
    chk({tag, ":done_cycle"}, done_at, exp_done);
    chk({tag, ":done_cnt"}, done_cnt, 1);
    chk({tag, ":busy_cycles"}, busy_cnt, exp_done - 1);
    chk({tag, ":missed"}, miss_cnt, exp_missed);
    if (exp_len > 0) chk({tag, ":data_hold"}, int'(o_data), 32'h100 + exp_len - 1);
  endtask

  task automatic idle(input int n);
    flag = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    sel = 1'b0; flag = 1'b0; ns_in = '0; nr_in = 16'd1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:ctrl", int'({b_busy, b_done, b_miss, b_en, b_valid}), 0);
    chk("rst:data", int'(b_data), 0);
    chk("rst:addr", int'(b_addr), 0);

    // Flag already high at reset release must not start playback
    flag = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_busy || b_en || b_valid) act++;
    end
    chk("flag_at_release", act, 0);
    idle(2);

    run_burst("len4", 4, 1, 4, 1, 1'b0, 1'b0, 0);
    run_burst("b2b", 2, 1, 2, 1, 1'b0, 1'b0, 0);
    idle(2);
    run_burst("len3x3", 3, 3, 3, 3, 1'b0, 1'b0, 0);
    idle(2);
    run_burst("len0", 0, 4, 0, 1, 1'b0, 1'b0, 0);
    idle(2);
    run_burst("reps0", 2, 0, 2, 1, 1'b0, 1'b0, 0);
    idle(2);

    // Held level plus a mid-burst re-pulse, with inputs changing during playback
    run_burst("hold", 4, 1, 4, 1, 1'b1, 1'b1, 1);
    act = 0;
    repeat (4) begin
      @(negedge clk);
      if (b_busy || b_en) act++;
    end
    chk("hold_no_retrig", act, 0);
    idle(2);

    // Asynchronous reset in the middle of PLAY
    ns_in = 15'd8; nr_in = 16'd1; flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst:pre_busy", int'(b_busy & b_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst:ctrl", int'({b_busy, b_done, b_miss, b_en, b_valid}), 0);
    chk("midrst:data", int'(b_data), 0);
    chk("midrst:addr", int'(b_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    run_burst("after_rst", 4, 2, 4, 2, 1'b0, 1'b0, 0);
    idle(2);

    // Full 2^ADDR_W length on the small instance
    sel = 1'b1;
    idle(2);
    run_burst("small16", 16, 2, 16, 2, 1'b0, 1'b0, 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
